// File: rtl/lt_round_ctrl_pkg.sv
// Shared encodings for the linear-transform round controller: FSM states,
// algorithm selector codes and register-file (ReF) write-mode codes.
// Configuration macro LT_ROUND_CTRL_ABORT_EN is consumed by lt_round_ctrl only.
package lt_round_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_MIX_LO = 3'd2,
      ST_MIX_HI = 3'd3,
      ST_LT     = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Algorithm selector; codes 3..7 fall back to the MDS fold path
   localparam logic [2:0] ALG_MDS   = 3'd0;
   localparam logic [2:0] ALG_SPN24 = 3'd1;
   localparam logic [2:0] ALG_SPN32 = 3'd2;

   // ReF write modes
   localparam logic [2:0] REF_D    = 3'd0;
   localparam logic [2:0] REF_REC1 = 3'd1;
   localparam logic [2:0] REF_P    = 3'd2;
   localparam logic [2:0] REF_LT24 = 3'd3;
   localparam logic [2:0] REF_LT32 = 3'd4;
   localparam logic [2:0] REF_REC0 = 3'd5;

   // SPN algorithms run one LT cycle per round; everything else folds in two halves
   function automatic logic alg_is_spn(input logic [2:0] alg);
      return (alg == ALG_SPN24) || (alg == ALG_SPN32);
   endfunction

endpackage

// File: rtl/lt_round_ctrl.sv
// Round sequencer for the linear stage: LOAD, then N rounds of MIX_LO/MIX_HI (MDS) or LT (SPN), then a DONE pulse.
// Latency start->done: 2+2N cycles (MDS) or 2+N cycles (SPN); N=0 gives 2. All outputs registered.
// No backpressure: start is only accepted in IDLE, ignored otherwise. Optional abort port under LT_ROUND_CTRL_ABORT_EN.
module lt_round_ctrl
   import lt_round_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] alg_mode,
   input  logic       mode_enc_dec,
   input  logic [3:0] num_rounds,
`ifdef LT_ROUND_CTRL_ABORT_EN
   input  logic       abort,
`endif
   output logic [3:0] outer_round,
   output logic       sel_op,
   output logic       ACC_src_x,
   output logic [1:0] ACC_src_y,
   output logic       ReF_en,
   output logic [2:0] mode_ref,
   output logic [2:0] alg_mode_q,
   output logic       mode_enc_dec_q,
   output logic       busy,
   output logic       done
);

   state_t     r_state;
   logic [2:0] r_alg_mode;
   logic       r_mode_enc_dec;
   logic [3:0] r_num_rounds;
   logic [3:0] r_outer_round;
   logic       r_sel_op;
   logic [1:0] r_acc_src_y;
   logic       r_ref_en;
   logic [2:0] r_mode_ref;
   logic       r_busy;
   logic       r_done;

   state_t     w_next_state;
   state_t     w_round_start;
   logic       w_last_round;
   logic       w_accept;
   logic       w_sel_op;
   logic [1:0] w_acc_src_y;
   logic       w_ref_en;
   logic [2:0] w_mode_ref;
   logic       w_busy;

   assign w_accept      = (r_state == ST_IDLE) && start;
   assign w_round_start = alg_is_spn(r_alg_mode) ? ST_LT : ST_MIX_LO;
   // Only evaluated inside rounds, where r_num_rounds is at least 1
   assign w_last_round  = (r_outer_round == (r_num_rounds - 4'd1));

   // Next-state selection from registered state and the latched job fields
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next_state = ST_LOAD;
         ST_LOAD: begin
            if (r_num_rounds == 4'd0) w_next_state = ST_DONE;
            else                      w_next_state = w_round_start;
         end
         ST_MIX_LO: w_next_state = ST_MIX_HI;
         ST_MIX_HI,
         ST_LT:     w_next_state = w_last_round ? ST_DONE : w_round_start;
         ST_DONE:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
`ifdef LT_ROUND_CTRL_ABORT_EN
      // Abort only matters while a job is running; in IDLE start wins
      if (abort && r_busy) w_next_state = ST_DONE;
`endif
   end

   // Output decode for the state being entered, so the outputs can be registered
   always_comb begin
      w_sel_op    = 1'b0;
      w_acc_src_y = 2'b00;
      w_ref_en    = 1'b0;
      w_mode_ref  = REF_D;
      w_busy      = 1'b0;
      case (w_next_state)
         ST_LOAD: begin
            w_busy     = 1'b1;
            w_ref_en   = 1'b1;
            w_mode_ref = REF_P;
         end
         ST_MIX_LO: begin
            w_busy = 1'b1;
         end
         ST_MIX_HI: begin
            w_busy      = 1'b1;
            w_sel_op    = 1'b1;
            w_acc_src_y = 2'b10;
            w_ref_en    = 1'b1;
            w_mode_ref  = REF_D;
         end
         ST_LT: begin
            w_busy     = 1'b1;
            w_ref_en   = 1'b1;
            w_mode_ref = (r_alg_mode == ALG_SPN24) ? REF_LT24 : REF_LT32;
         end
         default: ;
      endcase
   end

   // FSM state, job latches, inline round counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_alg_mode     <= 3'd0;
         r_mode_enc_dec <= 1'b0;
         r_num_rounds   <= 4'd0;
         r_outer_round  <= 4'd0;
         r_sel_op       <= 1'b0;
         r_acc_src_y    <= 2'b00;
         r_ref_en       <= 1'b0;
         r_mode_ref     <= REF_D;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_sel_op    <= w_sel_op;
         r_acc_src_y <= w_acc_src_y;
         r_ref_en    <= w_ref_en;
         r_mode_ref  <= w_mode_ref;
         r_busy      <= w_busy;
         r_done      <= (w_next_state == ST_DONE);
         if (w_accept) begin
            r_alg_mode     <= alg_mode;
            r_mode_enc_dec <= mode_enc_dec;
            r_num_rounds   <= num_rounds;
            r_outer_round  <= 4'd0;
         end else if (((r_state == ST_MIX_HI) || (r_state == ST_LT)) &&
                      (w_next_state != ST_DONE)) begin
            // Advance only when another round follows, so the index never wraps
            r_outer_round <= r_outer_round + 4'd1;
         end
      end
   end

   assign outer_round    = r_outer_round;
   assign sel_op         = r_sel_op;
   assign ACC_src_x      = 1'b0;
   assign ACC_src_y      = r_acc_src_y;
   assign ReF_en         = r_ref_en;
   assign mode_ref       = r_mode_ref;
   assign alg_mode_q     = r_alg_mode;
   assign mode_enc_dec_q = r_mode_enc_dec;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule

// File: tb/tb_lt_round_ctrl.sv
// Scoreboard bench for lt_round_ctrl: jobs are expanded into per-cycle expected outputs,
// a monitor compares every busy/done cycle and checks quiet outputs while idle.
// Define LT_ROUND_CTRL_ABORT_EN to also exercise the abort port.
module tb_lt_round_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] alg_mode = 3'd0;
   logic       mode_enc_dec = 1'b0;
   logic [3:0] num_rounds = 4'd0;
`ifdef LT_ROUND_CTRL_ABORT_EN
   logic       abort = 1'b0;
`endif
   logic [3:0] outer_round;
   logic       sel_op;
   logic       ACC_src_x;
   logic [1:0] ACC_src_y;
   logic       ReF_en;
   logic [2:0] mode_ref;
   logic [2:0] alg_mode_q;
   logic       mode_enc_dec_q;
   logic       busy;
   logic       done;

   lt_round_ctrl dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .alg_mode(alg_mode),
      .mode_enc_dec(mode_enc_dec),
      .num_rounds(num_rounds),
`ifdef LT_ROUND_CTRL_ABORT_EN
      .abort(abort),
`endif
      .outer_round(outer_round),
      .sel_op(sel_op),
      .ACC_src_x(ACC_src_x),
      .ACC_src_y(ACC_src_y),
      .ReF_en(ReF_en),
      .mode_ref(mode_ref),
      .alg_mode_q(alg_mode_q),
      .mode_enc_dec_q(mode_enc_dec_q),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       sel;
      logic       accx;
      logic [1:0] accy;
      logic       ref_en;
      logic [2:0] mref;
      logic [3:0] rnd;
      logic [2:0] algq;
      logic       medq;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t o;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   free_at = 0;
   int   checks = 0;
   int   failures = 0;
   bit   end_phase = 1'b0;
   bit   mon_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t mk(input logic b, input logic d, input logic s, input logic [1:0] y,
                               input logic r, input logic [2:0] m, input int rnd,
                               input logic [2:0] a, input logic e);
      obs_t o;
      o.busy = b; o.done = d; o.sel = s; o.accx = 1'b0; o.accy = y; o.ref_en = r;
      o.mref = m; o.rnd = 4'(rnd); o.algq = a; o.medq = e;
      return o;
   endfunction

   function automatic void add(input int c, input obs_t o);
      exp_t e;
      e.cyc = c; e.o = o;
      q.push_back(e);
   endfunction

   // Reference: job accepted from the inputs sampled at the end of cycle k
   task automatic model_job(input int k, input logic [2:0] a, input logic m, input logic [3:0] n);
      int c;
      int kind;   // 0 = MDS fold, 3/4 = LT mode code
      c = k + 1;
      kind = (a == 3'd1) ? 3 : (a == 3'd2) ? 4 : 0;
      add(c, mk(1, 0, 0, 2'b00, 1, 3'd2, 0, a, m)); c++;
      for (int r = 0; r < int'(n); r++) begin
         if (kind == 0) begin
            add(c, mk(1, 0, 0, 2'b00, 0, 3'd0, r, a, m)); c++;
            add(c, mk(1, 0, 1, 2'b10, 1, 3'd0, r, a, m)); c++;
         end else begin
            add(c, mk(1, 0, 0, 2'b00, 1, 3'(kind), r, a, m)); c++;
         end
      end
      add(c, mk(0, 1, 0, 2'b00, 0, 3'd0, (n == 0) ? 0 : int'(n) - 1, a, m));
      free_at = c + 1;
   endtask

   // Present inputs for the current cycle; the model decides acceptance on its own
   task automatic drive(input logic s, input logic [2:0] a, input logic m, input logic [3:0] n);
      start = s; alg_mode = a; mode_enc_dec = m; num_rounds = n;
      if (s && cyc >= free_at) model_job(cyc, a, m, n);
      @(posedge clk); #1;
   endtask

   task automatic idle_until_free();
      while (cyc < free_at) drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      drive(1'b0, 3'd0, 1'b0, 4'd0);
   endtask

   // Monitor: pop and compare on every busy/done cycle, check quiet outputs otherwise
   initial begin
      obs_t act;
      exp_t e;
      while (!end_phase) begin
         @(negedge clk);
         act = {busy, done, sel_op, ACC_src_x, ACC_src_y, ReF_en, mode_ref, outer_round, alg_mode_q, mode_enc_dec_q};
         if (!rst_n) begin
            checks++;
            if (act != '0) begin
               failures++;
               $display("FAIL reset_state cyc=%0d actual=%h required=0", cyc, act);
            end
         end else if (busy || done) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               checks++; failures++;
               $display("FAIL missed_output cyc=%0d actual=none required=%h@%0d", cyc, q[0].o, q[0].cyc);
               void'(q.pop_front());
            end
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output cyc=%0d actual=%h required=nothing", cyc, act);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.o != act) begin
                  failures++;
                  $display("FAIL job_cycle cyc=%0d actual=%h required=%h@%0d", cyc, act, e.o, e.cyc);
               end
            end
         end else begin
            checks++;
            if (sel_op || ACC_src_x || ACC_src_y != 2'b00 || ReF_en || mode_ref != 3'd0) begin
               failures++;
               $display("FAIL idle_controls cyc=%0d actual=%h required=controls_zero", cyc, act);
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d_pending required=0 head=%h@%0d", q.size(), q[0].o, q[0].cyc);
      end
      mon_done = 1'b1;
   end

   initial begin
      int k;
      int guard;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // MDS N=3, SPN32 N=4 with mode_enc_dec=1, SPN24 N=0, MDS max rounds, out-of-range alg
      drive(1'b1, 3'd0, 1'b0, 4'd3); idle_until_free();
      drive(1'b1, 3'd2, 1'b1, 4'd4); idle_until_free();
      drive(1'b1, 3'd1, 1'b0, 4'd0); idle_until_free();
      drive(1'b1, 3'd0, 1'b1, 4'd15); idle_until_free();
      drive(1'b1, 3'd6, 1'b0, 4'd2); idle_until_free();

      // start held through the whole job and one cycle more: a second job only from IDLE
      for (int i = 0; i < 2 + 2 * 2 + 2; i++) drive(1'b1, 3'd0, 1'b0, 4'd2);
      idle_until_free();

      // Async reset during MIX_HI of round 1: job dropped, no done
      k = cyc;
      drive(1'b1, 3'd0, 1'b0, 4'd3);
      while (cyc < k + 5) drive(1'b0, 3'd0, 1'b0, 4'd0);
      rst_n = 1'b0;
      q.delete();
      free_at = 0;
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1'b1, 3'd0, 1'b0, 4'd2); idle_until_free();

`ifdef LT_ROUND_CTRL_ABORT_EN
      // abort alongside start in IDLE is ignored; abort in LT round 2 ends the job next cycle
      k = cyc;
      abort = 1'b1;
      drive(1'b1, 3'd1, 1'b0, 4'd5);
      abort = 1'b0;
      while (cyc < k + 4) drive(1'b0, 3'd0, 1'b0, 4'd0);
      while (q.size() > 0 && q[$].cyc > k + 4) void'(q.pop_back());
      add(k + 5, mk(0, 1, 0, 2'b00, 0, 3'd0, 2, 3'd1, 1'b0));
      free_at = k + 6;
      abort = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 4'd0);
      abort = 1'b0;
      idle_until_free();
`endif

      // Random traffic; inputs change every cycle, including while a job runs
      for (int i = 0; i < 600; i++)
         drive(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      idle_until_free();

      repeat (3) @(posedge clk);
      end_phase = 1'b1;
      guard = 0;
      while (!mon_done && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (!mon_done) $display("FAIL monitor_stall actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, mon_done ? failures : failures + 1);
      $finish;
   end

endmodule

// File: doc/lt_round_ctrl.md
LT_ROUND_CTRL -- requirements
Module: lt_round_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL have: start  in  1  job request pulse; alg_mode  in  3  0=MDS fold, 1=SPN24, 2=SPN32, 3..7 treated as 0.
REQ-003 SHALL have: mode_enc_dec  in  1  forwarded to linear stage; num_rounds  in  4  rounds per job.
REQ-004 SHALL have: outer_round  out  4  current round index; sel_op  out  1  fold half select.
REQ-005 SHALL have: ACC_src_x  out  1; ACC_src_y  out  2; ReF_en  out  1; mode_ref  out  3.
REQ-006 SHALL have: alg_mode_q  out  3 and mode_enc_dec_q  out  1, latched copies; busy  out  1; done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL implement states IDLE, LOAD, MIX_LO, MIX_HI, LT, DONE.
REQ-008 IDLE: busy=0; all control outputs 0; start=1 latches alg_mode, mode_enc_dec, num_rounds, clears outer_round, moves to LOAD.
REQ-009 LOAD (1 cycle): ReF_en=1, mode_ref=3'b010 (load P).
REQ-010 LOAD exit: num_rounds_q==0 -> DONE; alg_mode_q==1 or 2 -> LT; otherwise -> MIX_LO.
REQ-011 MIX_LO (1 cycle): sel_op=0, ReF_en=0; next MIX_HI.
REQ-012 MIX_HI (1 cycle): sel_op=1, ACC_src_x=0, ACC_src_y=2'b10, mode_ref=3'b000, ReF_en=1.
REQ-013 LT (1 cycle): ReF_en=1, mode_ref=3'b011 if alg_mode_q==1, 3'b100 if alg_mode_q==2.
REQ-014 Round end (exit of MIX_HI or LT): outer_round==num_rounds_q-1 -> DONE; else outer_round+1 and re-enter round-start state.
REQ-015 outer_round SHALL be 4-bit, registered, stable for a whole round; num_rounds_q=15 gives last index 14, no wrap.
REQ-016 DONE (1 cycle): done=1, busy=0, ReF_en=0; next IDLE; done never asserted elsewhere.
REQ-017 busy=1 in LOAD, MIX_LO, MIX_HI, LT.
REQ-018 start while not IDLE SHALL be ignored, with no latch and no queueing.
REQ-019 start in the DONE cycle SHALL be ignored; earliest accepted start is the following IDLE cycle.
REQ-020 Input changes after acceptance SHALL NOT affect the running job.
REQ-021 All outputs SHALL be registered or decoded from registered state only, with no combinational path from start.
REQ-022 Job latency from start accept to done: 2+2*N cycles (MDS) or 2+N cycles (SPN), N=num_rounds; N=0 gives 2.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE; all outputs, outer_round and latched fields become 0.
REQ-024 Reset mid-job SHALL abandon the job with no done pulse; operation resumes on the first clk edge after rst_n is released.

Configuration
REQ-025 Macro LT_ROUND_CTRL_ABORT_EN defined: extra port abort  in  1; abort=1 in any busy state forces DONE next cycle (done=1, ReF_en=0 in that cycle); abort and start in IDLE gives start priority.
REQ-026 Macro undefined: no abort port; behaviour exactly REQ-007..REQ-024.

Structure
REQ-027 Shared package SHALL hold the state enum, alg_mode codes (ALG_MDS=0, ALG_SPN24=1, ALG_SPN32=2) and mode_ref codes (REF_D=0, REF_REC1=1, REF_P=2, REF_LT24=3, REF_LT32=4, REF_REC0=5).
REQ-028 SHALL be a single module with no sub-modules; the round counter SHALL be inline.

Verification
REQ-029 alg_mode=0, N=3, start pulse -> LOAD, then MIX_LO/MIX_HI x3 with outer_round 0,1,2; done at cycle 8 after accept; ReF_en high in 4 cycles.
REQ-030 alg_mode=2, mode_enc_dec=1, N=4 -> mode_ref=4 for 4 cycles, outer_round 0..3, done at cycle 6; mode_enc_dec_q=1 throughout.
REQ-031 N=0, alg_mode=1 -> LOAD then DONE; done at cycle 2; no LT cycle.
REQ-032 start held high for the whole job plus 1 cycle -> exactly one job; second start only if still high in IDLE.
REQ-033 rst_n pulsed low during MIX_HI of round 1 -> outputs 0 immediately, no done; new start completes normally.
REQ-034 With LT_ROUND_CTRL_ABORT_EN, abort in LT of round 2 (N=5) -> DONE next cycle, done=1 once, then IDLE.
